// File: rtl/uart_tx_engine_pkg.sv
// uart_tx_engine_pkg: shared FSM state encodings and status bit positions for the UART TX engine
package uart_tx_engine_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_e;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
endpackage

// File: rtl/uart_tx_engine_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered empty/full flags and push-drop indication
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i, data_i  write request and data
//   pop_i, data_o   read request and head-of-queue data
//   empty_o, full_o registered occupancy flags
//   drop_o          push refused because full with no simultaneous pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_pop  = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign data_o  = mem_q[rd_q];
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
    end else begin
      wr_q    <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q    <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q   <= cnt_d;
      empty_o <= cnt_d == '0;
      full_o  <= cnt_d == (AW+1)'(DEPTH);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: captures 6809 data-register writes into a FIFO and serialises them as 8N1 frames
//   clk, reset        13.3 MHz oscillator, asynchronous active-low reset
//   i_uart_data_ce, i_RW, i_E, i_DATA  asynchronous 6809 bus write to the data register
//   i_irq_en, i_clr_ovf                TX-empty interrupt enable, sticky overflow clear pulse
//   o_UART_RX         serial line toward the FT2232, idles high
//   o_tx_status       {4'b0, overflow, busy, fifo_full, fifo_empty}
//   o_tx_irq          registered TX-empty interrupt request
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int CLKS_PER_BIT = 115,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_uart_data_ce,
  input  logic       i_RW,
  input  logic       i_E,
  input  logic [7:0] i_DATA,
  input  logic       i_irq_en,
  input  logic       i_clr_ovf,
  output logic       o_UART_RX,
  output logic [7:0] o_tx_status,
  output logic       o_tx_irq
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  tx_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, head;
  logic line_q, line_d, ovf_q, irq_q, last, pop, push, empty, full, drop;
  logic s1_q, s2_q, prev_q;
  // two-flop synchroniser then rising-edge detect: one push per E-high window
  assign push = s2_q & ~prev_q;
  assign last = baud_q == BW'(CLKS_PER_BIT - 1);
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (push),
    .pop_i  (pop),
    .data_i (i_DATA),
    .data_o (head),
    .empty_o(empty),
    .full_o (full),
    .drop_o (drop)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      s1_q    <= i_uart_data_ce & ~i_RW & i_E;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      ovf_q   <= drop ? 1'b1 : i_clr_ovf ? 1'b0 : ovf_q;
      irq_q   <= i_irq_en & empty & (state_q == IDLE);
    end
  // the line is registered, so each transition sets line_d to the level of the state being entered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          baud_d  = '0;
          line_d  = 1'b0;
        end
      START:
        if (last) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          line_d  = shift_q[0];
        end else baud_d = baud_q + BW'(1);
      DATA:
        if (last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          state_d = bit_q == 3'd7 ? STOP : DATA;
          bit_d   = bit_q + 3'd1;
          line_d  = bit_q == 3'd7 ? 1'b1 : shift_q[1];
        end else baud_d = baud_q + BW'(1);
      STOP:
        if (last) begin
          baud_d  = '0;
          pop     = ~empty;
          shift_d = empty ? shift_q : head;
          state_d = empty ? IDLE : START;
          line_d  = empty;
        end else baud_d = baud_q + BW'(1);
    endcase
  end
  always_comb begin
    o_tx_status           = '0;
    o_tx_status[ST_EMPTY] = empty;
    o_tx_status[ST_FULL]  = full;
    o_tx_status[ST_BUSY]  = state_q != IDLE;
    o_tx_status[ST_OVF]   = ovf_q;
  end
  assign o_UART_RX = line_q;
  assign o_tx_irq  = irq_q;
endmodule
